// File: rtl/ray_pkg.sv
// Shared types and constants for the primary-ray generator.
// Directions and origins are signed Q16.16; sub-pixel offsets are in quarter pixels.
package ray_pkg;

  localparam int FRAC_W = 16;
  localparam logic signed [31:0] ONE = 32'sd65536;

  typedef struct packed {
    logic signed [31:0] x;
    logic signed [31:0] y;
    logic signed [31:0] z;
  } vec3_t;

  typedef struct packed {
    vec3_t origin;
    vec3_t dir;
  } ray_t;

  // Offset tables, two bits per sample, sample 0 in the least significant bits.
  localparam logic [7:0] OX_SPP1 = {2'd0, 2'd0, 2'd0, 2'd2};
  localparam logic [7:0] OY_SPP1 = {2'd0, 2'd0, 2'd0, 2'd2};
  localparam logic [7:0] OX_SPP2 = {2'd0, 2'd0, 2'd3, 2'd1};
  localparam logic [7:0] OY_SPP2 = {2'd0, 2'd0, 2'd3, 2'd1};
  localparam logic [7:0] OX_SPP4 = {2'd3, 2'd1, 2'd3, 2'd1};
  localparam logic [7:0] OY_SPP4 = {2'd3, 2'd3, 2'd1, 2'd1};

  // Returns {ox, oy} for a sample index at the given sample count.
  function automatic logic [3:0] sub_offset(input int spp, input logic [1:0] s);
    logic [7:0] tx;
    logic [7:0] ty;
    case (spp)
      4:       begin tx = OX_SPP4; ty = OY_SPP4; end
      2:       begin tx = OX_SPP2; ty = OY_SPP2; end
      default: begin tx = OX_SPP1; ty = OY_SPP1; end
    endcase
    return {tx[{s, 1'b0} +: 2], ty[{s, 1'b0} +: 2]};
  endfunction

endpackage

// File: rtl/generate_ray_array_if.sv
// Ray output stream: valid/ready handshake carrying the ray and its scan tags.
interface generate_ray_array_if;
  import ray_pkg::*;

  logic       ray_valid;
  logic       ray_ready;
  ray_t       ray_out;
  logic [9:0] ray_px;
  logic [9:0] ray_py;
  logic [1:0] ray_sample;
  logic       ray_last;

  modport master (
    output ray_valid, ray_out, ray_px, ray_py, ray_sample, ray_last,
    input  ray_ready
  );

  modport slave (
    input  ray_valid, ray_out, ray_px, ray_py, ray_sample, ray_last,
    output ray_ready
  );

endinterface

// File: rtl/pixel_scan_counter.sv
// Nested sample / x / y scan counters; advances one tuple per enabled cycle and wraps to zero.
// last flags the final tuple of the frame combinationally.
module pixel_scan_counter #(
  parameter int PIXEL_W = 800,
  parameter int PIXEL_H = 600,
  parameter int SPP     = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       en,
  output logic [9:0] px,
  output logic [9:0] py,
  output logic [1:0] sample,
  output logic       last
);

  localparam logic [9:0] X_MAX = 10'(PIXEL_W - 1);
  localparam logic [9:0] Y_MAX = 10'(PIXEL_H - 1);
  localparam logic [1:0] S_MAX = 2'(SPP - 1);

  logic s_wrap;
  logic x_wrap;
  logic y_wrap;

  assign s_wrap = (sample == S_MAX);
  assign x_wrap = (px == X_MAX);
  assign y_wrap = (py == Y_MAX);
  assign last   = s_wrap && x_wrap && y_wrap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      px     <= '0;
      py     <= '0;
      sample <= '0;
    end else if (clear) begin
      px     <= '0;
      py     <= '0;
      sample <= '0;
    end else if (en) begin
      if (!s_wrap) begin
        sample <= sample + 2'd1;
      end else begin
        sample <= '0;
        if (!x_wrap) begin
          px <= px + 10'd1;
        end else begin
          px <= '0;
          py <= y_wrap ? 10'd0 : py + 10'd1;
        end
      end
    end
  end

endmodule

// File: rtl/generate_ray_array.sv
// Pinhole-camera primary-ray generator: scan -> offset/subtract -> multiply/output, one ray per cycle.
// The whole pipeline and scan counters stall while an output ray waits for ray_ready.
module generate_ray_array
  import ray_pkg::*;
#(
  parameter int PIXEL_W  = 800,
  parameter int PIXEL_H  = 600,
  parameter int SPP      = 1,
  parameter int PIX_STEP = 55
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  vec3_t                       cam_origin,
  output logic                        busy,
  output logic                        frame_done,
  generate_ray_array_if.master        ray
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam logic signed [12:0] HALF_W = 13'(2 * PIXEL_W);
  localparam logic signed [12:0] HALF_H = 13'(2 * PIXEL_H);
  localparam logic signed [31:0] STEP   = 32'(PIX_STEP);

  logic [1:0] state;
  logic       pipe_en;
  logic       start_acc;
  logic       issue;

  logic [9:0] sc_px;
  logic [9:0] sc_py;
  logic [1:0] sc_s;
  logic       sc_last;

  assign pipe_en    = ray.ray_ready || !ray.ray_valid;
  assign start_acc  = start && (state == IDLE);
  assign issue      = (state == RUN) && pipe_en;
  assign busy       = (state != IDLE);
  assign frame_done = ray.ray_valid && ray.ray_ready && ray.ray_last;

  pixel_scan_counter #(
    .PIXEL_W (PIXEL_W),
    .PIXEL_H (PIXEL_H),
    .SPP     (SPP)
  ) u_scan (
    .clk    (clk),
    .rst    (rst),
    .clear  (start_acc),
    .en     (issue),
    .px     (sc_px),
    .py     (sc_py),
    .sample (sc_s),
    .last   (sc_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state <= RUN;
        RUN:     if (issue && sc_last) state <= DRAIN;
        DRAIN:   if (frame_done) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Stage 1: quarter-pixel position is {px, ox}, centred by subtracting half the image.
  logic [1:0]        ox;
  logic [1:0]        oy;
  logic signed [12:0] sx;
  logic signed [12:0] sy;
  logic signed [12:0] dx_n;
  logic signed [12:0] dy_n;

  assign {ox, oy} = sub_offset(SPP, sc_s);
  assign sx       = $signed({1'b0, sc_px, ox});
  assign sy       = $signed({1'b0, sc_py, oy});
  assign dx_n     = sx - HALF_W;
  assign dy_n     = HALF_H - sy;

  logic              v1;
  logic [9:0]        px1;
  logic [9:0]        py1;
  logic [1:0]        s1;
  logic              last1;
  logic signed [12:0] dx1;
  logic signed [12:0] dy1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1    <= 1'b0;
      px1   <= '0;
      py1   <= '0;
      s1    <= '0;
      last1 <= 1'b0;
      dx1   <= '0;
      dy1   <= '0;
    end else if (pipe_en) begin
      v1    <= (state == RUN);
      px1   <= sc_px;
      py1   <= sc_py;
      s1    <= sc_s;
      last1 <= sc_last;
      dx1   <= dx_n;
      dy1   <= dy_n;
    end
  end

  // Stage 2: scale by the quarter-pixel pitch; the product keeps its low 32 bits.
  logic signed [31:0] dx_ext;
  logic signed [31:0] dy_ext;
  logic signed [31:0] mul_x;
  logic signed [31:0] mul_y;

  assign dx_ext = {{19{dx1[12]}}, dx1};
  assign dy_ext = {{19{dy1[12]}}, dy1};
  assign mul_x  = dx_ext * STEP;
  assign mul_y  = dy_ext * STEP;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ray.ray_valid  <= 1'b0;
      ray.ray_out    <= '0;
      ray.ray_px     <= '0;
      ray.ray_py     <= '0;
      ray.ray_sample <= '0;
      ray.ray_last   <= 1'b0;
    end else begin
      // Origin only changes in IDLE, when the pipeline is already empty.
      if (start_acc) ray.ray_out.origin <= cam_origin;
      if (pipe_en) begin
        ray.ray_valid     <= v1;
        ray.ray_out.dir.x <= mul_x;
        ray.ray_out.dir.y <= mul_y;
        ray.ray_out.dir.z <= -ONE;
        ray.ray_px        <= px1;
        ray.ray_py        <= py1;
        ray.ray_sample    <= s1;
        ray.ray_last      <= v1 && last1;
      end
    end
  end

endmodule

// File: tb/tb_generate_ray_array.sv
// Bench for generate_ray_array: two instances (SPP=1 and SPP=4) on a 4x2 image,
// every accepted ray checked against an index-based camera model.
module tb_generate_ray_array;
  import ray_pkg::*;

  localparam int W = 4;
  localparam int H = 2;
  localparam int STEP = 16384;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  logic  start1 = 1'b0;
  logic  start4 = 1'b0;
  vec3_t org1 = '0;
  vec3_t org4 = '0;
  logic  busy1, busy4, fd1, fd4;

  generate_ray_array_if if1();
  generate_ray_array_if if4();

  always #5 clk = ~clk;

  generate_ray_array #(.PIXEL_W(W), .PIXEL_H(H), .SPP(1), .PIX_STEP(STEP)) u_d1 (
    .clk(clk), .rst(rst), .start(start1), .cam_origin(org1),
    .busy(busy1), .frame_done(fd1), .ray(if1)
  );

  generate_ray_array #(.PIXEL_W(W), .PIXEL_H(H), .SPP(4), .PIX_STEP(STEP)) u_d4 (
    .clk(clk), .rst(rst), .start(start4), .cam_origin(org4),
    .busy(busy4), .frame_done(fd4), .ray(if4)
  );

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    int px; int py; int s; int dx; int dy; int last;
  } cap_t;

  typedef struct {
    int spp; int idx; int px; int py; int s; int dx; int dy; int last;
  } vec_t;

  cap_t  cap1[$];
  cap_t  cap4[$];
  int    cnt1 = 0, cnt4 = 0, fdcnt1 = 0, fdcnt4 = 0;
  vec3_t eorg1 = '0, eorg4 = '0;
  logic  hold1 = 1'b0, rnd = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int ox_of(input int spp, input int s);
    if (spp == 1) return 2;
    if (spp == 2) return (s == 0) ? 1 : 3;
    return (s % 2 == 0) ? 1 : 3;
  endfunction

  function automatic int oy_of(input int spp, input int s);
    if (spp == 1) return 2;
    if (spp == 2) return (s == 0) ? 1 : 3;
    return (s < 2) ? 1 : 3;
  endfunction

  // Model: ray k of a frame is fully determined by its index and the latched origin.
  task automatic check_ray(input string tag, input int spp, input int k,
                           input int px, input int py, input int s, input int last,
                           input int fd, input vec3_t o, input vec3_t d, input vec3_t eo);
    int es, epx, epy, elast;
    es    = k % spp;
    epx   = (k / spp) % W;
    epy   = k / (spp * W);
    elast = (k == spp * W * H - 1) ? 1 : 0;
    chk($sformatf("%s[%0d].px", tag, k), px, epx);
    chk($sformatf("%s[%0d].py", tag, k), py, epy);
    chk($sformatf("%s[%0d].sample", tag, k), s, es);
    chk($sformatf("%s[%0d].dir.x", tag, k), d.x, (4 * epx + ox_of(spp, es) - 2 * W) * STEP);
    chk($sformatf("%s[%0d].dir.y", tag, k), d.y, (2 * H - (4 * epy + oy_of(spp, es))) * STEP);
    chk($sformatf("%s[%0d].dir.z", tag, k), d.z, -65536);
    chk($sformatf("%s[%0d].org", tag, k), (o == eo) ? 1 : 0, 1);
    chk($sformatf("%s[%0d].last", tag, k), last, elast);
    chk($sformatf("%s[%0d].frame_done", tag, k), fd, elast);
  endtask

  // Sole driver of both ray_ready inputs.
  always @(posedge clk) begin
    #1;
    if1.ray_ready = hold1 ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
    if4.ray_ready = rnd ? ($urandom % 4 != 0) : 1'b1;
  end

  always @(negedge clk) begin
    cap_t c;
    if (rst) begin
      cnt1 = 0;
    end else begin
      if (start1 && !busy1) begin cnt1 = 0; fdcnt1 = 0; eorg1 = org1; cap1.delete(); end
      if (fd1) fdcnt1++;
      if (if1.ray_valid && if1.ray_ready) begin
        check_ray("d1", 1, cnt1, int'(if1.ray_px), int'(if1.ray_py), int'(if1.ray_sample),
                  int'(if1.ray_last), int'(fd1), if1.ray_out.origin, if1.ray_out.dir, eorg1);
        c.px = int'(if1.ray_px); c.py = int'(if1.ray_py); c.s = int'(if1.ray_sample);
        c.dx = if1.ray_out.dir.x; c.dy = if1.ray_out.dir.y; c.last = int'(if1.ray_last);
        cap1.push_back(c);
        cnt1++;
      end
    end
  end

  always @(negedge clk) begin
    cap_t c;
    if (rst) begin
      cnt4 = 0;
    end else begin
      if (start4 && !busy4) begin cnt4 = 0; fdcnt4 = 0; eorg4 = org4; cap4.delete(); end
      if (fd4) fdcnt4++;
      if (if4.ray_valid && if4.ray_ready) begin
        check_ray("d4", 4, cnt4, int'(if4.ray_px), int'(if4.ray_py), int'(if4.ray_sample),
                  int'(if4.ray_last), int'(fd4), if4.ray_out.origin, if4.ray_out.dir, eorg4);
        c.px = int'(if4.ray_px); c.py = int'(if4.ray_py); c.s = int'(if4.ray_sample);
        c.dx = if4.ray_out.dir.x; c.dy = if4.ray_out.dir.y; c.last = int'(if4.ray_last);
        cap4.push_back(c);
        cnt4++;
      end
    end
  end

  task automatic wait_idle(input string name);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!busy1 && !busy4) return;
    end
    chk({name, "_idle_timeout"}, 1, 0);
  endtask

  task automatic wait_cnt1(input int n);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cnt1 >= n) return;
    end
    chk("cnt_timeout", cnt1, n);
  endtask

  task automatic check_latency(input string name, input logic both);
    @(negedge clk);
    chk({name, "_busy"}, busy1, 1);
    chk({name, "_valid_c0"}, if1.ray_valid, 0);
    @(negedge clk);
    chk({name, "_valid_c1"}, if1.ray_valid, 0);
    @(negedge clk);
    chk({name, "_valid_c2"}, if1.ray_valid, 1);
    if (both) chk({name, "_valid4_c2"}, if4.ray_valid, 1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[9];
    logic [255:0] snap, cur;

    tbl[0] = '{1, 0,  0, 0, 0,  -98304,  32768, 0};
    tbl[1] = '{1, 5,  1, 1, 0,  -32768, -32768, 0};
    tbl[2] = '{1, 7,  3, 1, 0,   98304, -32768, 1};
    tbl[3] = '{4, 0,  0, 0, 0, -114688,  49152, 0};
    tbl[4] = '{4, 1,  0, 0, 1,  -81920,  49152, 0};
    tbl[5] = '{4, 2,  0, 0, 2, -114688,  16384, 0};
    tbl[6] = '{4, 3,  0, 0, 3,  -81920,  16384, 0};
    tbl[7] = '{4, 12, 3, 0, 0,   81920,  49152, 0};
    tbl[8] = '{4, 31, 3, 1, 3,  114688, -49152, 1};

    // Reset held for two cycles.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy1", busy1, 0);       chk("rst_busy4", busy4, 0);
    chk("rst_valid1", if1.ray_valid, 0); chk("rst_valid4", if4.ray_valid, 0);
    chk("rst_done1", fd1, 0);         chk("rst_done4", fd4, 0);
    chk("rst_last1", if1.ray_last, 0);   chk("rst_last4", if4.ray_last, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Frame A: full frames on both instances, plus a start pulse while busy.
    org1 = '{x: 32'sd65536, y: -32'sd131072, z: 32'sd7};
    org4 = '{x: -32'sd5, y: 32'sd12345, z: 32'sd99};
    @(posedge clk); #1 start1 = 1'b1; start4 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0; start4 = 1'b0;
    check_latency("frameA", 1'b1);
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    wait_idle("frameA");
    repeat (4) @(negedge clk);
    chk("busy_start_ignored_busy", busy1, 0);
    chk("frameA_rays1", cap1.size(), 8);
    chk("frameA_rays4", cap4.size(), 32);
    chk("frameA_done1", fdcnt1, 1);
    chk("frameA_done4", fdcnt4, 1);

    foreach (tbl[i]) begin
      cap_t c;
      if ((tbl[i].spp == 1 ? cap1.size() : cap4.size()) <= tbl[i].idx) begin
        chk($sformatf("tbl%0d_missing", i), 0, 1);
      end else begin
        c = (tbl[i].spp == 1) ? cap1[tbl[i].idx] : cap4[tbl[i].idx];
        chk($sformatf("tbl%0d_px", i), c.px, tbl[i].px);
        chk($sformatf("tbl%0d_py", i), c.py, tbl[i].py);
        chk($sformatf("tbl%0d_s", i), c.s, tbl[i].s);
        chk($sformatf("tbl%0d_dx", i), c.dx, tbl[i].dx);
        chk($sformatf("tbl%0d_dy", i), c.dy, tbl[i].dy);
        chk($sformatf("tbl%0d_last", i), c.last, tbl[i].last);
      end
    end

    // Frame B: five-cycle backpressure after three rays.
    org1 = '{x: 32'sd1, y: 32'sd2, z: 32'sd3};
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    wait_cnt1(3);
    hold1 = 1'b1;
    @(negedge clk);
    chk("stall_valid", if1.ray_valid, 1);
    snap = {36'd0, if1.ray_out, if1.ray_px, if1.ray_py, if1.ray_sample, if1.ray_last, if1.ray_valid};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cur = {36'd0, if1.ray_out, if1.ray_px, if1.ray_py, if1.ray_sample, if1.ray_last, if1.ray_valid};
      nvec++;
      if (cur !== snap) begin
        nerr++;
        $display("FAIL stall_hold%0d: got %h expected %h", i, cur, snap);
      end
    end
    hold1 = 1'b0;
    wait_idle("frameB");
    chk("frameB_rays1", cap1.size(), 8);

    // Frame C: random backpressure; restart in the cycle right after frame_done.
    rnd = 1'b1;
    @(posedge clk); #1 start1 = 1'b1; start4 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0; start4 = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (fd1) break;
      if (i == 299) chk("fd1_timeout", 0, 1);
    end
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    check_latency("restart", 1'b0);
    wait_idle("frameC");
    chk("frameC_rays1", cap1.size(), 8);
    chk("frameC_rays4", cap4.size(), 32);
    rnd = 1'b0;

    // Reset mid-frame after three rays, then restart with a new origin.
    org1 = '{x: 32'sd777, y: 32'sd888, z: -32'sd999};
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    wait_cnt1(3);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", busy1, 0);
    chk("midrst_valid", if1.ray_valid, 0);
    chk("midrst_last", if1.ray_last, 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_no_done", fdcnt1, 0);
    org1 = '{x: -32'sd4096, y: 32'sd8192, z: 32'sd16384};
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    wait_idle("after_rst");
    chk("after_rst_rays", cap1.size(), 8);
    chk("after_rst_done", fdcnt1, 1);
    if (cap1.size() > 0) begin
      chk("after_rst_px0", cap1[0].px, 0);
      chk("after_rst_py0", cap1[0].py, 0);
      chk("after_rst_s0", cap1[0].s, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/generate_ray_array.md
GENERATE_RAY_ARRAY -- requirements
Module: generate_ray_array

Interface
REQ-001 Parameter PIXEL_W, default 800: image width in pixels, 2..1024.
REQ-002 Parameter PIXEL_H, default 600: image height in pixels, 2..1024.
REQ-003 Parameter SPP, default 1: samples per pixel, legal values 1, 2 and 4.
REQ-004 Parameter PIX_STEP, default 55: image-plane size of a quarter pixel, Q16.16 fixed point.
REQ-005 Port clk, input, 1 bit: the only clock; all logic is rising-edge.
REQ-006 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 Port start, input, 1 bit: single-cycle pulse that begins a frame.
REQ-008 Port cam_origin, input, vec3_t: camera position, sampled on an accepted start.
REQ-009 Port busy, output, 1 bit: high from an accepted start until frame_done.
REQ-010 Port frame_done, output, 1 bit: one-cycle pulse when the last ray is accepted.
REQ-011 Port ray_valid, output, 1 bit: ray_out and its tags are valid.
REQ-012 Port ray_ready, input, 1 bit: consumer accepts the ray.
REQ-013 Port ray_out, output, ray_t: generated ray (origin and direction).
REQ-014 Ports ray_px and ray_py, output, 10 bits each: pixel coordinates of ray_out.
REQ-015 Port ray_sample, output, 2 bits: sample index within the pixel.
REQ-016 Port ray_last, output, 1 bit: ray_out is the final ray of the frame.

Function
REQ-017 The FSM SHALL have three states:
- IDLE to RUN on start.
- RUN to DRAIN once the final scan tuple has been issued into the pipeline.
- DRAIN to IDLE when the final ray is accepted.
REQ-018 Scan order SHALL nest sample innermost, then px (0..PIXEL_W-1), then py (0..PIXEL_H-1).
REQ-019 Quarter-pixel sample coordinates (sx, sy) SHALL be 4*px+ox and 4*py+oy, with (ox, oy) as follows:
- SPP=1: (2,2).
- SPP=2: (1,1), (3,3).
- SPP=4: (1,1), (3,1), (1,3), (3,3).
REQ-020 The direction SHALL be computed as:
- dir.x = (sx - 2*PIXEL_W) * PIX_STEP.
- dir.y = (2*PIXEL_H - sy) * PIX_STEP.
- dir.z = -65536.
- All components are signed 32-bit Q16.16 and the direction is not normalised.
REQ-021 Subtraction SHALL be done at 13 bits signed before multiplying; the product SHALL be truncated to 32 bits.
REQ-022 ray_out.origin SHALL equal cam_origin as latched at the accepted start, for the whole frame.
REQ-023 The pipeline SHALL have two register stages (offset/subtract, then multiply/output), so the first ray_valid appears 2 cycles after start is accepted.
REQ-024 With ray_ready held high, one ray SHALL be produced per cycle, PIXEL_W*PIXEL_H*SPP rays in total.
REQ-025 The pipeline enable SHALL be (ray_ready OR NOT ray_valid); while ray_valid=1 and ray_ready=0, all outputs SHALL hold stable and the scan counters SHALL freeze.
REQ-026 ray_px, ray_py, ray_sample and ray_last SHALL travel through the pipeline aligned with ray_out.
REQ-027 start SHALL be ignored while busy=1, including on the cycle frame_done pulses.
REQ-028 A start in the cycle after frame_done SHALL be accepted normally.
REQ-029 ray_last SHALL be 1 only on the ray with px=PIXEL_W-1, py=PIXEL_H-1, sample=SPP-1.

Reset
REQ-030 Asserting rst SHALL immediately:
- set state to IDLE;
- set busy, frame_done, ray_valid and ray_last to 0;
- clear the scan counters, pipeline valids and latched origin to 0.
REQ-031 rst asserted mid-frame SHALL abort the frame with no frame_done pulse; the next start SHALL restart scanning at (0,0,0).

Structure
REQ-032 Package ray_pkg SHALL hold:
- vec3_t (three signed 32-bit Q16.16 values);
- ray_t (origin and dir, both vec3_t);
- constants FRAC_W=16, ONE=65536, and the sub-pixel offset tables.
REQ-033 One sub-module SHALL exist: pixel_scan_counter, containing the nested sample/x/y counters with enable, wrap and last-tuple flag.

Verification
REQ-034 Reset: assert rst for 2 cycles -> busy=0, ray_valid=0, frame_done=0, ray_last=0.
REQ-035 Full frame at PIXEL_W=4, PIXEL_H=2, SPP=1, PIX_STEP=16384, ray_ready=1 -> exactly 8 rays, 2 cycles after start.
- The first ray is (0,0) with dir=(-98304, 32768, -65536).
- ray_last and the frame_done pulse occur on the 8th ray.
REQ-036 Backpressure: drop ray_ready for 5 cycles mid-frame -> ray_out and tags stay unchanged, with no rays lost or duplicated.
REQ-037 SPP=4 at PIXEL_W=4, PIXEL_H=2 -> 32 rays; pixel (0,0) samples dir.x = -114688, -81920, -114688, -81920.
REQ-038 Pulse start while busy -> ignored, and the ray count stays at 8.
REQ-039 Assert rst after 3 rays, then start -> no frame_done pulse; the restart begins at (0,0,0) with the newly sampled cam_origin.
